// File: rtl/fuse_rd_arbiter_pkg.sv
// Shared types and constants for the fuse read-port arbiter.
// Holds the arbiter FSM encoding and default field widths.
package fuse_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int FUSE_WORD_W = 32;
   localparam int DEF_ADDR_W  = 7;
   localparam int DEF_LEN_W   = 4;

endpackage

// File: rtl/fuse_rd_arbiter_if.sv
// Client-side request/return bus plus the fuse memory read port.
// The slave modport is the arbiter's view; master is the clients-and-fuse side.
interface fuse_rd_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = fuse_arb_pkg::DEF_ADDR_W,
   parameter int LEN_W   = fuse_arb_pkg::DEF_LEN_W
);
   import fuse_arb_pkg::*;

   logic [NUM_REQ-1:0]             rd_req_i;
   logic [NUM_REQ-1:0][ADDR_W-1:0] rd_base_i;
   logic [NUM_REQ-1:0][LEN_W-1:0]  rd_len_i;
   logic [NUM_REQ-1:0]             rd_gnt_o;
   logic [NUM_REQ-1:0]             rd_err_o;
   logic [NUM_REQ-1:0]             rd_valid_o;
   logic [FUSE_WORD_W-1:0]         rd_data_o;
   logic                           rd_last_o;
   logic                           fuse_req_o;
   logic [FUSE_WORD_W-1:0]         fuse_addr_o;
   logic [FUSE_WORD_W-1:0]         fuse_rdata_i;

   modport slave (
      input  rd_req_i, rd_base_i, rd_len_i, fuse_rdata_i,
      output rd_gnt_o, rd_err_o, rd_valid_o, rd_data_o, rd_last_o,
             fuse_req_o, fuse_addr_o
   );

   modport master (
      output rd_req_i, rd_base_i, rd_len_i, fuse_rdata_i,
      input  rd_gnt_o, rd_err_o, rd_valid_o, rd_data_o, rd_last_o,
             fuse_req_o, fuse_addr_o
   );

endinterface

// File: rtl/fuse_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_id,
// wrapping, returned both as a one-hot vector and as an index.
module fuse_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_id,
   output logic [NUM_REQ-1:0] onehot,
   output logic [ID_W-1:0]    index
);

   always_comb begin
      logic            found;
      logic [ID_W-1:0] cand;
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(last_id) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found        = 1'b1;
            onehot[cand] = 1'b1;
            index        = cand;
         end
      end
   end

endmodule

// File: rtl/fuse_rd_arbiter.sv
// Round-robin arbiter sharing the fuse read port between key-loading clients,
// with bounds/window checking before any fuse access.
module fuse_rd_arbiter
   import fuse_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MEM_SIZE = 100,
   parameter int ADDR_W   = $clog2(MEM_SIZE),
   parameter int MAX_LEN  = 8,
   parameter int LEN_W    = DEF_LEN_W,
   parameter logic [NUM_REQ-1:0][ADDR_W-1:0] WIN_LO = '0,
   parameter logic [NUM_REQ-1:0][ADDR_W-1:0] WIN_HI = {NUM_REQ{ADDR_W'(MEM_SIZE - 1)}}
) (
   input logic              clk_i,
   input logic              rst_i,
   fuse_rd_arbiter_if.slave bus
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e                 state, state_n;
   logic [ID_W-1:0]        last_id, win_id;
   logic [NUM_REQ-1:0]     win_oh, gnt, err, w_oh, vld_p1;
   logic [ADDR_W-1:0]      sel_base, cur;
   logic [LEN_W-1:0]       sel_len, rem;
   logic [ADDR_W:0]        end_sum;
   logic                   legal, take, fuse_req, last_p1;
   logic [FUSE_WORD_W-1:0] fuse_addr;

   fuse_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req     (bus.rd_req_i),
      .last_id (last_id),
      .onehot  (win_oh),
      .index   (win_id)
   );

   assign sel_base = bus.rd_base_i[win_id];
   assign sel_len  = bus.rd_len_i[win_id];
   // One extra bit so base+len cannot wrap before the MEM_SIZE compare.
   assign end_sum  = {1'b0, sel_base} + (ADDR_W + 1)'(sel_len);

   always_comb begin
      legal = (sel_len != '0)
           && (sel_len <= LEN_W'(MAX_LEN))
           && (sel_base >= WIN_LO[win_id])
           && ((end_sum - (ADDR_W + 1)'(1)) <= {1'b0, WIN_HI[win_id]})
           && (end_sum <= (ADDR_W + 1)'(MEM_SIZE));
   end

   always_comb begin
      state_n   = state;
      gnt       = '0;
      err       = '0;
      take      = 1'b0;
      fuse_req  = 1'b0;
      fuse_addr = '0;
      unique case (state)
         IDLE: begin
            // Gated by reset so gnt/err read as 0 while reset is held.
            if (!rst_i && (|bus.rd_req_i)) begin
               if (legal) begin
                  gnt     = win_oh;
                  take    = 1'b1;
                  state_n = BURST;
               end else begin
                  err = win_oh;
               end
            end
         end
         BURST: begin
            fuse_req  = 1'b1;
            fuse_addr = {{(FUSE_WORD_W - ADDR_W){1'b0}}, cur};
            if (rem == LEN_W'(1)) state_n = DRAIN;
         end
         DRAIN: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         last_id <= ID_W'(NUM_REQ - 1);
         vld_p1  <= '0;
         last_p1 <= 1'b0;
      end else begin
         state <= state_n;
         if ((|gnt) || (|err)) last_id <= win_id;
         // p1: fuse memory returns the word one cycle after the request.
         vld_p1  <= fuse_req ? w_oh : '0;
         last_p1 <= fuse_req && (rem == LEN_W'(1));
      end
   end

   always_ff @(posedge clk_i) begin
      if (take) begin
         w_oh <= win_oh;
         cur  <= sel_base;
         rem  <= sel_len;
      end else if (fuse_req) begin
         cur <= cur + ADDR_W'(1);
         rem <= rem - LEN_W'(1);
      end
   end

   assign bus.rd_gnt_o    = gnt;
   assign bus.rd_err_o    = err;
   assign bus.rd_valid_o  = vld_p1;
   assign bus.rd_last_o   = last_p1;
   assign bus.rd_data_o   = (|vld_p1) ? bus.fuse_rdata_i : '0;
   assign bus.fuse_req_o  = fuse_req;
   assign bus.fuse_addr_o = fuse_addr;

endmodule
